// File: rtl/duft_pkg.sv
// duft_pkg: shared state encoding and default sizes for the DUFT host driver
package duft_pkg;
  localparam int DUFT_DATA_W = 32;
  localparam int DUFT_SCAN_LEN = 64;
  localparam int DUFT_TO_CYC = 255;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_CMT, ACK, SCAN, RESP} duft_host_state_e;
endpackage

// File: rtl/duft_host_driver_if.sv
// duft_host_driver_if: host command/response, DUT op/commit and scan signals of one driver
interface duft_host_driver_if
  import duft_pkg::*;
#(
  parameter int DATA_W = DUFT_DATA_W,
  parameter int SCAN_LEN = DUFT_SCAN_LEN
);
  logic cmd_val, cmd_rdy, cmd_scan;
  logic [DATA_W-1:0] cmd_data, dut_data_in, dut_data_out, rsp_data;
  logic val_op, op_ack, op_commit, commit_ack;
  logic sen, scan_ce, sin, sout;
  logic rsp_val, rsp_rdy, rsp_timeout;
  logic [SCAN_LEN-1:0] rsp_scan;
  modport master (
    input cmd_val, cmd_data, cmd_scan, dut_data_out, op_ack, op_commit, sout, rsp_rdy,
    output cmd_rdy, dut_data_in, val_op, commit_ack, sen, scan_ce, sin, rsp_val, rsp_data, rsp_scan, rsp_timeout
  );
  modport slave (
    output cmd_val, cmd_data, cmd_scan, dut_data_out, op_ack, op_commit, sout, rsp_rdy,
    input cmd_rdy, dut_data_in, val_op, commit_ack, sen, scan_ce, sin, rsp_val, rsp_data, rsp_scan, rsp_timeout
  );
endinterface

// File: rtl/duft_scan_capture.sv
// duft_scan_capture: recirculating scan dump, one cell per cycle LSB first while i_start is held
module duft_scan_capture
  import duft_pkg::*;
#(
  parameter int SCAN_LEN = DUFT_SCAN_LEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic                i_sout,
  output logic                o_done,
  output logic                o_sen,
  output logic                o_scan_ce,
  output logic                o_sin,
  output logic [SCAN_LEN-1:0] o_scan
);
  localparam int CW = $clog2(SCAN_LEN + 1);
  logic [CW-1:0] r_cnt;
  logic [SCAN_LEN-1:0] r_scan;
  always_ff @(posedge clk)
    r_cnt <= (reset || !i_start) ? '0 : r_cnt + 1'b1;
  always_ff @(posedge clk)
    if (reset) r_scan <= '0;
    else if (i_start)
      for (int i = 0; i < SCAN_LEN; i++)
        if (r_cnt == CW'(i)) r_scan[i] <= i_sout;
  assign o_done = i_start && r_cnt == CW'(SCAN_LEN - 1);
  assign o_sen = i_start;
  assign o_scan_ce = i_start;
  assign o_sin = i_start & i_sout;
  assign o_scan = r_scan;
endmodule

// File: rtl/duft_host_driver.sv
// duft_host_driver: host-to-DUT op/commit/scan driver; DUFT_TIMEOUT_EN adds a watchdog on ISSUE/WAIT_CMT
module duft_host_driver
  import duft_pkg::*;
#(
  parameter int DATA_W = DUFT_DATA_W,
  parameter int SCAN_LEN = DUFT_SCAN_LEN
`ifdef DUFT_TIMEOUT_EN
  , parameter int TO_CYC = DUFT_TO_CYC
`endif
) (
  input logic clk,
  input logic reset,
  duft_host_driver_if.master bus
);
  duft_host_state_e r_state, w_next;
  logic r_scan_req, w_scan_done, w_to;
  logic [DATA_W-1:0] r_din, r_rsp_data;
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = bus.cmd_val ? ISSUE : IDLE;
      ISSUE:    w_next = (bus.op_ack && bus.op_commit) ? ACK : w_to ? RESP : bus.op_ack ? WAIT_CMT : ISSUE;
      WAIT_CMT: w_next = bus.op_commit ? ACK : w_to ? RESP : WAIT_CMT;
      ACK:      w_next = r_scan_req ? SCAN : RESP;
      SCAN:     w_next = w_scan_done ? RESP : SCAN;
      RESP:     w_next = bus.rsp_rdy ? IDLE : RESP;
      default:  w_next = IDLE;
    endcase
  end
  always_comb begin
    bus.cmd_rdy = r_state == IDLE;
    bus.val_op = r_state == ISSUE;
    bus.commit_ack = r_state == ACK;
    bus.rsp_val = r_state == RESP;
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_din <= '0;
      r_scan_req <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      if (r_state == IDLE && bus.cmd_val) begin
        r_din <= bus.cmd_data;
        r_scan_req <= bus.cmd_scan;
      end
      if (r_state == ACK) r_rsp_data <= bus.dut_data_out;
      else if (w_to && w_next == RESP) r_rsp_data <= '0;
    end
  assign bus.dut_data_in = r_din;
  assign bus.rsp_data = r_rsp_data;
`ifdef DUFT_TIMEOUT_EN
  localparam int WD_W = $clog2(TO_CYC + 1) > 8 ? $clog2(TO_CYC + 1) : 8;
  logic [WD_W-1:0] r_wd;
  logic r_timeout, w_wait;
  assign w_wait = r_state == ISSUE || r_state == WAIT_CMT;
  // fires on the TO_CYC-th waiting cycle; a simultaneous commit still wins
  assign w_to = w_wait && r_wd == WD_W'(TO_CYC - 1);
  always_ff @(posedge clk)
    if (reset) begin
      r_wd <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_wd <= w_wait ? r_wd + 1'b1 : '0;
      r_timeout <= (w_to && w_next == RESP) ? 1'b1 : (r_state == IDLE && bus.cmd_val) ? 1'b0 : r_timeout;
    end
  assign bus.rsp_timeout = r_timeout;
`else
  assign w_to = 1'b0;
  assign bus.rsp_timeout = 1'b0;
`endif
  duft_scan_capture #(.SCAN_LEN(SCAN_LEN)) u_scan (
    .clk(clk),
    .reset(reset),
    .i_start(r_state == SCAN),
    .i_sout(bus.sout),
    .o_done(w_scan_done),
    .o_sen(bus.sen),
    .o_scan_ce(bus.scan_ce),
    .o_sin(bus.sin),
    .o_scan(bus.rsp_scan)
  );
endmodule

// File: tb/tb_duft_host_driver.sv
// tb_duft_host_driver: table and random transactions checked against cycle counts derived from the handshake rules
module tb_duft_host_driver;
  import duft_pkg::*;
  localparam int SL = DUFT_SCAN_LEN;
  typedef struct {
    logic [31:0] data;
    bit          scan;
    int          ack;
    int          cmt;
    int          rdly;
    logic [31:0] result;
    int          exp_lat;
    int          exp_vop;
    logic [31:0] exp_data;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, load = 1'b0;
  logic [SL-1:0] load_val = '0, chain, gold = '0, img = '0;
  int n_vec = 0, n_err = 0;
  vec_t tbl[6];
  vec_t v;
  duft_host_driver_if bus ();
  duft_host_driver dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.sout = chain[0];
  // behavioural DUT scan chain: shifts toward bit 0, sin enters at the top
  always @(posedge clk)
    if (load) chain <= load_val;
    else if (bus.scan_ce) chain <= {bus.sin, chain[SL-1:1]};

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic preload(input logic [SL-1:0] val);
    @(posedge clk); #1;
    load = 1'b1; load_val = val; gold = val;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic run(input vec_t t);
    int vop = 0, cak = 0, cak_at = -1, sce = 0, rv_at = -1, rv_n = 0;
    bit din_ok = 1, sin_ok = 1, hold_ok = 1, done = 0;
    int ack_cyc = 1 + t.ack;
    int cmt_cyc = 1 + t.ack + t.cmt;
    if (t.scan) img = gold;
    @(posedge clk); #1;
    bus.cmd_val = 1'b1; bus.cmd_data = t.data; bus.cmd_scan = t.scan;
    @(negedge clk);
    chk("cmd_rdy", bus.cmd_rdy, 1);
    for (int c = 1; c < 400 && !done; c++) begin
      @(posedge clk); #1;
      bus.cmd_val = 1'b0; bus.cmd_data = $urandom; bus.cmd_scan = 1'($urandom);
      bus.op_ack = c == ack_cyc || bus.sen || bus.rsp_val;
      bus.op_commit = c == cmt_cyc || bus.sen || bus.rsp_val;
      bus.dut_data_out = c == cmt_cyc + 1 ? t.result : ~t.result;
      bus.rsp_rdy = rv_n >= t.rdly;
      @(negedge clk);
      vop += int'(bus.val_op);
      sce += int'(bus.scan_ce);
      if (bus.commit_ack) begin cak++; cak_at = c; end
      if (c <= cmt_cyc + 1 && bus.dut_data_in !== t.data) din_ok = 0;
      if (bus.sin && !bus.sen) sin_ok = 0;
      if (bus.rsp_val) begin
        if (rv_at < 0) rv_at = c;
        if (bus.rsp_data !== t.exp_data || bus.cmd_rdy) hold_ok = 0;
        rv_n++;
        done = bus.rsp_rdy;
      end
    end
    chk("rsp_lat", rv_at, t.exp_lat);
    chk("val_op_cycles", vop, t.exp_vop);
    chk("commit_ack_n", cak, 1);
    chk("commit_ack_at", cak_at, cmt_cyc + 1);
    chk("scan_ce_n", sce, t.scan ? SL : 0);
    chk("din_hold", din_ok, 1);
    chk("sin_gate", sin_ok, 1);
    chk("rsp_hold", hold_ok, 1);
    chk("rsp_stall", rv_n, t.rdly + 1);
    chk("rsp_data", bus.rsp_data, t.exp_data);
    chk("rsp_scan", bus.rsp_scan, img);
    chk("chain_kept", chain, gold);
    @(posedge clk); #1;
    bus.op_ack = 1'b0; bus.op_commit = 1'b0; bus.rsp_rdy = 1'b0;
    @(negedge clk);
    chk("cmd_rdy_back", {bus.cmd_rdy, bus.rsp_val}, 2'b10);
    chk("din_idle", bus.dut_data_in, t.data);
  endtask

  initial begin
    bus.cmd_val = 0; bus.cmd_data = 0; bus.cmd_scan = 0; bus.dut_data_out = 0;
    bus.op_ack = 0; bus.op_commit = 0; bus.rsp_rdy = 0;
    tbl[0] = '{32'h0000_0005, 1'b0, 0, 1, 0, 32'h0000_0006, 4, 1, 32'h0000_0006};
    tbl[1] = '{32'h1234_5678, 1'b0, 3, 2, 0, 32'hDEAD_BEEF, 8, 4, 32'hDEAD_BEEF};
    tbl[2] = '{32'hCAFE_0001, 1'b0, 1, 0, 1, 32'h0BAD_F00D, 4, 2, 32'h0BAD_F00D};
    tbl[3] = '{32'h0000_00FF, 1'b1, 0, 1, 0, 32'h1357_9BDF, 68, 1, 32'h1357_9BDF};
    tbl[4] = '{32'hFFFF_FFFF, 1'b1, 2, 0, 0, 32'h0000_0000, 69, 3, 32'h0000_0000};
    tbl[5] = '{32'h8000_0000, 1'b0, 0, 1, 5, 32'h7FFF_FFFF, 4, 1, 32'h7FFF_FFFF};
    repeat (2) @(posedge clk);
    #1 load = 1'b1; load_val = 64'hA5A5_0000_FFFF_1234; gold = load_val;
    @(posedge clk); #1 load = 1'b0; reset = 1'b0;
    @(negedge clk);
    chk("reset_ctl", {bus.cmd_rdy, bus.val_op, bus.commit_ack, bus.sen, bus.scan_ce, bus.sin, bus.rsp_val, bus.rsp_timeout}, 8'h80);
    chk("reset_data", {bus.rsp_data, bus.dut_data_in}, 0);
    chk("reset_scan", bus.rsp_scan, 0);
    for (int i = 0; i < 6; i++) run(tbl[i]);
    for (int k = 0; k < 20; k++) begin
      if (k % 5 == 0) preload({$urandom, $urandom});
      v.data = $urandom; v.scan = $urandom_range(0, 3) == 0;
      v.ack = $urandom_range(0, 4); v.cmt = $urandom_range(0, 4); v.rdly = $urandom_range(0, 3);
      v.result = $urandom; v.exp_data = v.result;
      v.exp_lat = 3 + v.ack + v.cmt + (v.scan ? SL : 0);
      v.exp_vop = v.ack + 1;
      run(v);
    end
    @(posedge clk); #1 bus.cmd_val = 1'b1; bus.cmd_scan = 1'b1; bus.cmd_data = 32'h55;
    @(posedge clk); #1 bus.cmd_val = 1'b0; bus.op_ack = 1'b1; bus.op_commit = 1'b1;
    @(posedge clk); #1 bus.op_ack = 1'b0; bus.op_commit = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("mid_scan_sen", bus.sen, 1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("scan_rst_ctl", {bus.cmd_rdy, bus.val_op, bus.commit_ack, bus.sen, bus.scan_ce, bus.sin, bus.rsp_val, bus.rsp_timeout}, 8'h80);
    chk("scan_rst_data", {bus.rsp_data, bus.dut_data_in}, 0);
    chk("scan_rst_scan", bus.rsp_scan, 0);
    img = '0;
    preload(gold);
    run(tbl[0]);
`ifdef DUFT_TIMEOUT_EN
    begin : to_seq
      int c;
      @(posedge clk); #1 bus.cmd_val = 1'b1; bus.cmd_scan = 1'b0;
      @(posedge clk); #1 bus.cmd_val = 1'b0; bus.op_ack = 1'b1; c = 1;
      while (!bus.rsp_val && c < 400) begin
        @(posedge clk); #1 bus.op_ack = 1'b0; c++;
      end
      chk("to_cycles", c, 256);
      chk("to_flag", bus.rsp_timeout, 1);
      chk("to_data", bus.rsp_data, 0);
      bus.rsp_rdy = 1'b1;
      @(posedge clk); #1 bus.rsp_rdy = 1'b0;
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
